mac_sequencer: RTL and testbench

- Control stage directly upstream of signed_multiplier (combinational 8-bit MAC: out = weight*value + cumulative, int8 or fp8, saturating, overflow flag).
- Accepts a stream of (weight, value) pairs over valid/ready and drives them into the multiplier one per cycle.
- Registers the multiplier's out as the next cumulative, and returns the final dot-product with a sticky overflow flag over a valid/ready result port.
- Multiplier is external; this block only drives and samples its ports.

---
 rtl/mac_sequencer.sv | 152 +++++++++++++++
 tb/tb_mac_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mac_sequencer.sv
// Sequencer that streams (weight, value) pairs into an external signed_multiplier MAC
// and returns the accumulated result. Optional bias preload: define MAC_SEQ_BIAS_EN.
module mac_sequencer #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             float_mode,
`ifdef MAC_SEQ_BIAS_EN
    input  logic [7:0]       bias,
`endif
    input  logic             in_valid,
    input  logic [7:0]       in_weight,
    input  logic [7:0]       in_value,
    output logic             in_ready,
    output logic [7:0]       mac_weight,
    output logic [7:0]       mac_value,
    output logic [7:0]       mac_cumulative,
    output logic             mac_float,
    input  logic [7:0]       mac_out,
    input  logic             mac_overflow,
    output logic             busy,
    output logic             res_valid,
    output logic [7:0]       res_data,
    output logic             res_overflow,
    input  logic             res_ready
);

    // Handshakes: a beat moves on a rising edge where valid && ready are both high;
    // the producer holds valid and its payload steady until then.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       acc_q, acc_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             mode_q, mode_d;
    logic             ovf_q, ovf_d;

    logic             xfer;
    logic             last_pair;
    logic [7:0]       acc_init;

`ifdef MAC_SEQ_BIAS_EN
    assign acc_init = bias;
`else
    assign acc_init = 8'h00;
`endif

    assign xfer      = (state_q == ACCUM) && in_valid;
    assign last_pair = (count_q == (len_q - LEN_W'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= 8'h00;
            count_q <= '0;
            len_q   <= '0;
            mode_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        len_d   = len_q;
        mode_d  = mode_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = acc_init;
                    ovf_d   = 1'b0;
                    count_d = '0;
                    if (len != '0) begin
                        len_d   = len;
                        mode_d  = float_mode;
                        state_d = ACCUM;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            ACCUM: begin
                if (xfer) begin
                    // acc takes the multiplier result verbatim; saturation lives there.
                    acc_d   = mac_out;
                    ovf_d   = ovf_q | mac_overflow;
                    count_d = count_q + LEN_W'(1);
                    if (last_pair) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready       = 1'b0;
        busy           = 1'b0;
        res_valid      = 1'b0;
        res_data       = 8'h00;
        res_overflow   = 1'b0;
        mac_weight     = 8'h00;
        mac_value      = 8'h00;
        mac_cumulative = 8'h00;
        mac_float      = 1'b0;
        case (state_q)
            ACCUM: begin
                in_ready       = 1'b1;
                busy           = 1'b1;
                mac_weight     = in_weight;
                mac_value      = in_value;
                mac_cumulative = acc_q;
                mac_float      = mode_q;
            end
            DONE: begin
                busy         = 1'b1;
                res_valid    = 1'b1;
                res_data     = acc_q;
                res_overflow = ovf_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer: a stand-in multiplier, driver tasks, and a
// scoreboard whose monitor checks every result handshake against an expected queue.
module tb_mac_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] len;
    logic       float_mode;
    logic       in_valid;
    logic [7:0] in_weight;
    logic [7:0] in_value;
    logic       in_ready;
    logic [7:0] mac_weight;
    logic [7:0] mac_value;
    logic [7:0] mac_cumulative;
    logic       mac_float;
    logic [7:0] mac_out;
    logic       mac_overflow;
    logic       busy;
    logic       res_valid;
    logic [7:0] res_data;
    logic       res_overflow;
    logic       res_ready;

    int total = 0;
    int bad   = 0;
    logic [8:0] exp_q[$];
    logic       last_float;

    always #5 clk = ~clk;

    mac_sequencer #(.LEN_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .float_mode(float_mode),
`ifdef MAC_SEQ_BIAS_EN
        .bias(8'h00),
`endif
        .in_valid(in_valid), .in_weight(in_weight), .in_value(in_value),
        .in_ready(in_ready), .mac_weight(mac_weight), .mac_value(mac_value),
        .mac_cumulative(mac_cumulative), .mac_float(mac_float),
        .mac_out(mac_out), .mac_overflow(mac_overflow), .busy(busy),
        .res_valid(res_valid), .res_data(res_data), .res_overflow(res_overflow),
        .res_ready(res_ready)
    );

    // Stand-in multiplier: saturating int8 MAC, plus the few fp8 points the bench uses.
    int mp;
    always_comb begin
        mp           = 0;
        mac_out      = 8'h00;
        mac_overflow = 1'b0;
        if (!mac_float) begin
            mp = $signed(mac_weight) * $signed(mac_value) + $signed(mac_cumulative);
            if (mp > 127) begin
                mac_out = 8'h7F; mac_overflow = 1'b1;
            end else if (mp < -128) begin
                mac_out = 8'h80; mac_overflow = 1'b1;
            end else begin
                mac_out = mp[7:0];
            end
        end else if (mac_weight == 8'h38 && mac_value == 8'h38) begin
            if (mac_cumulative == 8'h00)      mac_out = 8'h38;
            else if (mac_cumulative == 8'h38) mac_out = 8'h40;
        end
    end

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_start(input logic [7:0] l, input logic fm);
        start = 1'b1; len = l; float_mode = fm;
        tick();
        start = 1'b0;
    endtask

    // Present one pair and hold it until the sequencer takes it.
    task automatic send_pair(input logic [7:0] w, input logic [7:0] v);
        bit done = 0;
        in_valid = 1'b1; in_weight = w; in_value = v;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                last_float = mac_float;
                done = 1;
            end
            tick();
        end
        if (!done) check("pair_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            if (!busy) done = 1;
            else tick();
        end
        if (!done) check("idle_timeout", 0, 1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Monitor: every result handshake pops and compares one expected entry.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("res_data", int'(res_data), int'(e[7:0]));
                check("res_overflow", int'(res_overflow), int'(e[8]));
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; len = 8'd0; float_mode = 1'b0;
        in_valid = 1'b0; in_weight = 8'h00; in_value = 8'h00; res_ready = 1'b1;
        last_float = 1'b0;
        idle_cycles(2);
        rst = 1'b0;
        check("reset_outs", int'({in_ready, busy, res_valid, res_data, res_overflow}), 0);
        check("reset_mac", int'({mac_weight, mac_value, mac_cumulative, mac_float}), 0);

        // Int dot product 2*4 + 3*5 = 23.
        do_start(8'd2, 1'b0);
        check("busy_accum", int'(busy), 1);
        exp_q.push_back({1'b0, 8'h17});
        send_pair(8'd2, 8'd4);
        send_pair(8'd3, 8'd5);
        check("res_latency", int'(res_valid), 1);
        wait_idle();

        // Saturation with sticky overflow.
        do_start(8'd2, 1'b0);
        exp_q.push_back({1'b1, 8'h7F});
        send_pair(8'd100, 8'd2);
        send_pair(8'd1, 8'd1);
        wait_idle();

        // fp8: 1.0*1.0 + 1.0*1.0 = 2.0.
        do_start(8'd2, 1'b1);
        exp_q.push_back({1'b0, 8'h40});
        send_pair(8'h38, 8'h38);
        check("fp8_float_1", int'(last_float), 1);
        send_pair(8'h38, 8'h38);
        check("fp8_float_2", int'(last_float), 1);
        wait_idle();

        // Input stalls, then result backpressure with ignored start pulses.
        res_ready = 1'b0;
        do_start(8'd3, 1'b0);
        exp_q.push_back({1'b0, 8'h0E});
        send_pair(8'd1, 8'd1);
        idle_cycles(4);
        check("stall_acc", int'(mac_cumulative), 1);
        check("stall_ready", int'(in_ready), 1);
        send_pair(8'd2, 8'd2);
        idle_cycles(4);
        check("stall_acc2", int'(mac_cumulative), 5);
        send_pair(8'd3, 8'd3);
        for (int i = 0; i < 5; i++) begin
            start = 1'b1; len = 8'd1;
            tick();
            check("hold_valid", int'(res_valid), 1);
            check("hold_data", int'(res_data), 8'h0E);
            check("hold_busy", int'(busy), 1);
        end
        res_ready = 1'b1;
        tick();
        start = 1'b0;
        check("start_on_handshake", int'(busy), 0);
        check("idle_in_ready", int'(in_ready), 0);
        tick();
        check("idle_stays", int'(busy), 0);

        // len = 0 goes straight to DONE.
        exp_q.push_back({1'b0, 8'h00});
        do_start(8'd0, 1'b0);
        check("len0_valid", int'(res_valid), 1);
        check("len0_in_ready", int'(in_ready), 0);
        wait_idle();

        // Reset mid-vector, then a fresh one-pair vector 7 * -1.
        do_start(8'd3, 1'b0);
        send_pair(8'd5, 8'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_outs", int'({in_ready, busy, res_valid, res_data, res_overflow}), 0);
        check("midrst_mac", int'({mac_weight, mac_value, mac_cumulative, mac_float}), 0);
        do_start(8'd1, 1'b0);
        exp_q.push_back({1'b0, 8'hF9});
        send_pair(8'd7, 8'hFF);
        wait_idle();
        idle_cycles(2);

        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
